bnn_frame_sequencer: RTL and testbench

//  Sequences one BNN inference per 5-byte command frame from the SPI byte path.

---
 rtl/bnn_frame_sequencer_if.sv | 20 ++
 rtl/bnn_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_bnn_frame_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_frame_sequencer_if.sv
// Byte-command and result handshake between the SPI byte path, the frame
// sequencer and the result consumer.
interface bnn_frame_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] res_data;
  logic       res_valid;
  logic       res_ready;

  modport master (
    output cmd_data, cmd_valid, res_ready,
    input  cmd_ready, res_data, res_valid
  );

  modport slave (
    input  cmd_data, cmd_valid, res_ready,
    output cmd_ready, res_data, res_valid
  );
endinterface

// File: rtl/bnn_frame_sequencer.sv
// Runs one BNN inference per 5-byte command frame: assembles operands, pulses
// bnn_start, waits for bnn_done and hands the class result out on a valid/ready port.
module bnn_frame_sequencer #(
  parameter int unsigned FRAME_BYTES  = 5,
  parameter int unsigned DONE_TIMEOUT = 255,
  parameter int unsigned GAP_TIMEOUT  = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  bnn_frame_sequencer_if.slave   host,
  output logic [3:0]             bnn_input,
  output logic [15:0]            bnn_weights,
  output logic [15:0]            bnn_bias,
  output logic                   bnn_start,
  input  logic                   bnn_done,
  input  logic [3:0]             bnn_result,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned DoneW    = $clog2(DONE_TIMEOUT + 1);
  localparam int unsigned GapW     = $clog2(GAP_TIMEOUT + 1);
  localparam logic [2:0]  LastByte = 3'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {StLoad, StFire, StWait, StResult, StError} state_e;

  state_e           state_q;
  logic [2:0]       byte_cnt_q;
  logic [DoneW-1:0] done_tmr_q;
  logic [GapW-1:0]  gap_tmr_q;
  logic [3:0]       input_q;
  logic [15:0]      weights_q;
  logic [15:0]      bias_q;
  logic             cmd_ready_q;
  logic             start_q;
  logic             res_valid_q;
  logic [3:0]       res_data_q;
  logic             busy_q;
  logic             err_q;
  logic             accept;

  // cmd_ready_q is only high in LOAD/ERROR, so this is the byte handshake.
  assign accept = host.cmd_valid & cmd_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      byte_cnt_q  <= '0;
      done_tmr_q  <= '0;
      gap_tmr_q   <= '0;
      input_q     <= '0;
      weights_q   <= '0;
      bias_q      <= '0;
      cmd_ready_q <= 1'b1;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            gap_tmr_q <= '0;
            case (byte_cnt_q)
              3'd0:    input_q         <= host.cmd_data[3:0];
              3'd1:    weights_q[7:0]  <= host.cmd_data;
              3'd2:    weights_q[15:8] <= host.cmd_data;
              3'd3:    bias_q[7:0]     <= host.cmd_data;
              3'd4:    bias_q[15:8]    <= host.cmd_data;
              default: ;
            endcase
            if (byte_cnt_q == LastByte) begin
              byte_cnt_q  <= '0;
              state_q     <= StFire;
              start_q     <= 1'b1;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end else if (byte_cnt_q != '0) begin
            // Stalled partial frame: drop it but keep the operand registers.
            if (gap_tmr_q == GapW'(GAP_TIMEOUT - 1)) begin
              byte_cnt_q <= '0;
              gap_tmr_q  <= '0;
              err_q      <= 1'b1;
            end else begin
              gap_tmr_q <= gap_tmr_q + 1'b1;
            end
          end
        end
        StFire: begin
          state_q    <= StWait;
          done_tmr_q <= '0;
        end
        StWait: begin
          // done is checked first so a completion on the timeout cycle still counts.
          if (bnn_done) begin
            res_data_q  <= bnn_result;
            res_valid_q <= 1'b1;
            state_q     <= StResult;
          end else if (done_tmr_q == DoneW'(DONE_TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= StError;
          end else begin
            done_tmr_q <= done_tmr_q + 1'b1;
          end
        end
        StResult: begin
          if (host.res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StLoad;
          end
        end
        StError: begin
          if (accept) begin
            err_q      <= 1'b0;
            input_q    <= host.cmd_data[3:0];
            byte_cnt_q <= 3'd1;
            gap_tmr_q  <= '0;
            busy_q     <= 1'b0;
            state_q    <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.res_valid = res_valid_q;
  assign host.res_data  = res_data_q;
  assign bnn_input      = input_q;
  assign bnn_weights    = weights_q;
  assign bnn_bias       = bias_q;
  assign bnn_start      = start_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_bnn_frame_sequencer.sv
// Directed bench for bnn_frame_sequencer: frame assembly, result handshake,
// done timeout, inter-byte gap timeout, mid-WAIT reset and done-at-timeout.
module tb_bnn_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  bnn_input;
  logic [15:0] bnn_weights;
  logic [15:0] bnn_bias;
  logic        bnn_start;
  logic        bnn_done;
  logic [3:0]  bnn_result;
  logic        busy;
  logic        err;
  int          total = 0;
  int          bad   = 0;

  bnn_frame_sequencer_if bus ();

  bnn_frame_sequencer #(
    .FRAME_BYTES (5),
    .DONE_TIMEOUT(8),
    .GAP_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (bus.slave),
    .bnn_input  (bnn_input),
    .bnn_weights(bnn_weights),
    .bnn_bias   (bnn_bias),
    .bnn_start  (bnn_start),
    .bnn_done   (bnn_done),
    .bnn_result (bnn_result),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("send_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
  endtask

  // From just after FIRE was entered: move to WAIT, complete with r.
  task automatic finish_frame(input logic [3:0] r);
    tick();
    bnn_done   = 1'b1;
    bnn_result = r;
    tick();
    bnn_done   = 1'b0;
    bnn_result = 4'h0;
  endtask

  task automatic accept_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("res_accept_valid", 32'(bus.res_valid), 32'd0);
    check("res_accept_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_start"}, 32'(bnn_start), 32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(bus.res_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_input"}, 32'(bnn_input), 32'd0);
    check({tag, "_weights"}, 32'(bnn_weights), 32'd0);
    check({tag, "_bias"}, 32'(bnn_bias), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_data  = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    bnn_done      = 1'b0;
    bnn_result    = 4'h0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // T1: back-to-back frame, start one cycle after B4, result 0x9
    send_byte(8'h0A);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h78);
    check("t1_no_early_start", 32'(bnn_start), 32'd0);
    send_byte(8'h56);
    check("t1_start", 32'(bnn_start), 32'd1);
    check("t1_input", 32'(bnn_input), 32'hA);
    check("t1_weights", 32'(bnn_weights), 32'h1234);
    check("t1_bias", 32'(bnn_bias), 32'h5678);
    check("t1_fire_ready", 32'(bus.cmd_ready), 32'd0);
    check("t1_fire_busy", 32'(busy), 32'd1);
    tick();
    check("t1_start_pulse", 32'(bnn_start), 32'd0);
    tick();
    bnn_done   = 1'b1;
    bnn_result = 4'h9;
    check("t1_valid_not_yet", 32'(bus.res_valid), 32'd0);
    tick();
    bnn_done   = 1'b0;
    bnn_result = 4'h0;
    check("t1_res_valid", 32'(bus.res_valid), 32'd1);
    check("t1_res_data", 32'(bus.res_data), 32'h9);
    check("t1_result_ready", 32'(bus.cmd_ready), 32'd0);
    accept_result();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // T2: pending result blocks the next byte until res_ready
    send_frame(8'h03, 8'h11, 8'h22, 8'h33, 8'h44);
    finish_frame(4'h6);
    bus.cmd_data  = 8'h0C;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("t2_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("t2_valid_held", 32'(bus.res_valid), 32'd1);
    check("t2_data_held", 32'(bus.res_data), 32'h6);
    check("t2_not_taken", 32'(bnn_input), 32'h3);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t2_released", 32'(bus.res_valid), 32'd0);
    check("t2_ready_back", 32'(bus.cmd_ready), 32'd1);
    check("t2_still_old", 32'(bnn_input), 32'h3);
    tick();
    bus.cmd_valid = 1'b0;
    check("t2_b0_taken", 32'(bnn_input), 32'hC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check("t2_start", 32'(bnn_start), 32'd1);
    check("t2_weights", 32'(bnn_weights), 32'h0201);
    check("t2_bias", 32'(bnn_bias), 32'h0403);

    // T3: no done -> err after 8 WAIT cycles, byte in ERROR restarts frame
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("t3_err_early", 32'(err), 32'd0);
    tick();
    check("t3_err", 32'(err), 32'd1);
    check("t3_no_valid", 32'(bus.res_valid), 32'd0);
    check("t3_err_ready", 32'(bus.cmd_ready), 32'd1);
    check("t3_err_busy", 32'(busy), 32'd1);
    send_byte(8'h05);
    check("t3_err_clear", 32'(err), 32'd0);
    check("t3_input", 32'(bnn_input), 32'h5);
    check("t3_load_busy", 32'(busy), 32'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    check("t3_start", 32'(bnn_start), 32'd1);
    check("t3_weights", 32'(bnn_weights), 32'hBBAA);
    check("t3_bias", 32'(bnn_bias), 32'hDDCC);
    finish_frame(4'hF);
    check("t3_res_data", 32'(bus.res_data), 32'hF);
    accept_result();

    // T4: two bytes, 16 idle cycles -> partial frame dropped
    send_byte(8'h01);
    send_byte(8'hEE);
    for (int i = 0; i < 15; i++) tick();
    check("t4_err_early", 32'(err), 32'd0);
    tick();
    check("t4_err", 32'(err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    send_frame(8'h07, 8'h21, 8'h43, 8'h65, 8'h87);
    check("t4_start", 32'(bnn_start), 32'd1);
    check("t4_input", 32'(bnn_input), 32'h7);
    check("t4_weights", 32'(bnn_weights), 32'h4321);
    check("t4_bias", 32'(bnn_bias), 32'h8765);
    finish_frame(4'h2);
    check("t4_res_data", 32'(bus.res_data), 32'h2);
    check("t4_err_sticky", 32'(err), 32'd1);
    accept_result();

    // T5: reset during WAIT, late done ignored
    send_frame(8'h09, 8'h99, 8'h88, 8'h77, 8'h66);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    bnn_done   = 1'b1;
    bnn_result = 4'hE;
    tick();
    bnn_done   = 1'b0;
    bnn_result = 4'h0;
    check_reset_state("t5");
    tick();
    check("t5_no_valid", 32'(bus.res_valid), 32'd0);
    send_frame(8'h04, 8'h10, 8'h20, 8'h30, 8'h40);
    check("t5_weights", 32'(bnn_weights), 32'h2010);
    check("t5_bias", 32'(bnn_bias), 32'h4030);
    finish_frame(4'h5);
    check("t5_res_valid", 32'(bus.res_valid), 32'd1);
    check("t5_res_data", 32'(bus.res_data), 32'h5);
    accept_result();

    // T6: done arrives on the final (8th) WAIT cycle
    send_frame(8'h06, 8'h01, 8'h00, 8'h02, 8'h00);
    tick();
    for (int i = 0; i < 7; i++) tick();
    bnn_done   = 1'b1;
    bnn_result = 4'hB;
    tick();
    bnn_done   = 1'b0;
    bnn_result = 4'h0;
    check("t6_res_valid", 32'(bus.res_valid), 32'd1);
    check("t6_res_data", 32'(bus.res_data), 32'hB);
    check("t6_err", 32'(err), 32'd0);
    accept_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
